// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every input vector of an N_IN-input gate, compares its output with a reference function.
// Latency: done at 2^N_IN*(SETTLE+1)+1 cycles after the accepted start (1 cycle when the mode is illegal).
// Backpressure: none; start is sampled only in IDLE, requests while busy or in DONE are dropped, not queued.
// Build option: define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module gate_sweep_checker #(
  parameter int N_IN   = 2,  // gate input count, 1..8
  parameter int SETTLE = 1   // idle cycles between driving a vector and sampling it, 0..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic              dut_out,
  output logic [N_IN-1:0]   dut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              illegal,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);
  localparam bit              NO_SETTLE = (SETTLE == 0);
  localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;
  localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);
  localparam logic [N_IN:0]   ERR_MAX   = ERR_ONE << N_IN;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  mode_q;
  logic [3:0]  settle_cnt;
  logic        exp_bit;
  logic        mismatch;
  logic        last_vec;
  logic        mode_legal;
  logic        stop_on_fail;

  assign mode_legal = (mode < 3'd6);
  assign last_vec   = (dut_in == VEC_LAST);
  assign mismatch   = (dut_out != exp_bit);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  assign stop_on_fail = mismatch;
`else
  assign stop_on_fail = 1'b0;
`endif

  // Reference value for the vector currently driven, as a reduction over all inputs.
  always_comb begin
    exp_bit = 1'b0;
    case (mode_q)
      3'd0:    exp_bit = ~|dut_in;
      3'd1:    exp_bit =  |dut_in;
      3'd2:    exp_bit = ~&dut_in;
      3'd3:    exp_bit =  &dut_in;
      3'd4:    exp_bit =  ^dut_in;
      3'd5:    exp_bit = ~^dut_in;
      default: exp_bit = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero settle time skips WAIT entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!mode_legal) begin
            state_nxt = S_DONE;
          end else if (NO_SETTLE) begin
            state_nxt = S_SAMPLE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Counter is about to reach zero on this edge.
        if (settle_cnt <= 4'd1) begin
          state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (last_vec || stop_on_fail) begin
          state_nxt = S_DONE;
        end else if (NO_SETTLE) begin
          state_nxt = S_SAMPLE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = (state == S_WAIT) || (state == S_SAMPLE);
    done = (state == S_DONE);
  end

  // Vector counter, settle timer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q           <= 3'd0;
      settle_cnt       <= 4'd0;
      dut_in           <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
      illegal          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q           <= mode;
            settle_cnt       <= SETTLE_LD;
            dut_in           <= '0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            illegal          <= !mode_legal;
          end
        end
        S_WAIT: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        S_SAMPLE: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) begin
              err_count <= err_count + ERR_ONE;
            end
            if (!first_fail_valid) begin
              first_fail_vec   <= dut_in;
              first_fail_valid <= 1'b1;
            end
          end
          if (last_vec || stop_on_fail) begin
            // Leaving for DONE: fold in this vector's result; only legal modes reach SAMPLE.
            pass <= !mismatch && (err_count == '0);
          end else begin
            dut_in     <= dut_in + VEC_ONE;
            settle_cnt <= SETTLE_LD;
          end
        end
        S_DONE: begin
          dut_in <= '0;
        end
        default: begin
          dut_in <= '0;
        end
      endcase
    end
  end

endmodule
